// File: rtl/aes_inv_key_sched_if.sv
// Handshake bundle between the inverse key schedule and its consumer.
// The master drives the request/acknowledge side; the slave (the key schedule) produces keys.
interface aes_inv_key_sched_if;
  logic         start;
  logic [127:0] key_in;
  logic         key_ready;
  logic [127:0] round_key;
  logic [3:0]   round_num;
  logic         key_valid;
  logic         busy;
  logic         done;

  modport master (
    output start, key_in, key_ready,
    input  round_key, round_num, key_valid, busy, done
  );

  modport slave (
    input  start, key_in, key_ready,
    output round_key, round_num, key_valid, busy, done
  );
endinterface

// File: rtl/aes_inv_key_sched.sv
// AES-128 decryption key schedule: loaded with round key 10, it walks the expansion
// backwards and hands out round keys 10..0, one per accepted valid/ready handshake.
module aes_inv_key_sched #(
  parameter int NR = 10
) (
  input logic                 clk,
  input logic                 rst,
  aes_inv_key_sched_if.slave  bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, EMIT = 2'd1, FINISH = 2'd2} state_e;

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [3:0] NR_L = 4'(NR);

  // Entry x sits at the top of the table for x = 0, so index from the MSB down.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TBL[{~x, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] c;
    case (r)
      4'd1:    c = 8'h01;
      4'd2:    c = 8'h02;
      4'd3:    c = 8'h04;
      4'd4:    c = 8'h08;
      4'd5:    c = 8'h10;
      4'd6:    c = 8'h20;
      4'd7:    c = 8'h40;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h1b;
      4'd10:   c = 8'h36;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  state_e       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   rnum_q, rnum_d;
  logic         valid_q, valid_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  logic [31:0]  w0_s, w1_s, w2_s, w3_s;
  logic [31:0]  w0p_s, w1p_s, w2p_s, w3p_s;
  logic [31:0]  rot_s, sub_s;
  logic [127:0] prev_key_s;

  // Undo one expansion step; SubWord uses the forward S-box on the recovered w3.
  always_comb begin
    w0_s  = key_q[127:96];
    w1_s  = key_q[95:64];
    w2_s  = key_q[63:32];
    w3_s  = key_q[31:0];
    w3p_s = w3_s ^ w2_s;
    w2p_s = w2_s ^ w1_s;
    w1p_s = w1_s ^ w0_s;
    rot_s = {w3p_s[23:0], w3p_s[31:24]};
    sub_s = {sbox(rot_s[31:24]), sbox(rot_s[23:16]), sbox(rot_s[15:8]), sbox(rot_s[7:0])};
    w0p_s = w0_s ^ sub_s ^ {rcon(rnum_q), 24'h000000};
    prev_key_s = {w0p_s, w1p_s, w2p_s, w3p_s};
  end

  // Next-state and output-register decode.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    rnum_d  = rnum_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          key_d   = bus.key_in;
          rnum_d  = NR_L;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          state_d = EMIT;
        end else begin
          state_d = IDLE;
        end
      end
      EMIT: begin
        if (valid_q && bus.key_ready) begin
          if (rnum_q != 4'd0) begin
            key_d  = prev_key_s;
            rnum_d = rnum_q - 4'd1;
          end else begin
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = FINISH;
          end
        end else begin
          state_d = EMIT;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= 128'h0;
      rnum_q  <= 4'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      rnum_q  <= rnum_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.round_key = key_q;
  assign bus.round_num = rnum_q;
  assign bus.key_valid = valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Scoreboard bench for aes_inv_key_sched: expected keys come from a forward key
// expansion in software; a negedge monitor pops and checks every accepted key.
module tb_aes_inv_key_sched;

  localparam logic [2047:0] SB = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [127:0] A1_KEY0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] A1_KEY9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] A1_KEY10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  logic clk;
  logic rst;
  aes_inv_key_sched_if bus ();

  aes_inv_key_sched #(.NR(10)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int ready_mode = 0;
  logic [131:0] sb_q [$];
  logic [127:0] ek [11];

  function automatic logic [7:0] sbf(input logic [7:0] x);
    logic [10:0] base;
    base = 11'(255 - int'(x)) << 3;
    return SB[base +: 8];
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sbf(t[31:24]), sbf(t[23:16]), sbf(t[15:8]), sbf(t[7:0])};
  endfunction

  // Forward FIPS-197 expansion; Rcon generated by repeated xtime.
  task automatic expand(input logic [127:0] k0);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    w[0] = k0[127:96]; w[1] = k0[95:64]; w[2] = k0[63:32]; w[3] = k0[31:0];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = rc[7] ? ((rc << 1) ^ 8'h1b) : (rc << 1);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) ek[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge: pushes the expected 10..0 sequence and pulses start for one cycle.
  task automatic issue_start(input logic [127:0] kin);
    for (int r = 10; r >= 0; r--) sb_q.push_back({4'(r), ek[r]});
    bus.start  = 1'b1;
    bus.key_in = kin;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.key_in = 128'h0;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      if (bus.done) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: got no done pulse expected one within 400 cycles");
    end
  endtask

  task automatic wait_round(input logic [3:0] r);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      if (bus.key_valid && bus.round_num == r) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL round_timeout: round %0d never presented", r);
    end
  endtask

  // Consumer: ready changes just after each rising edge.
  initial begin
    bus.key_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.key_ready = (ready_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  logic         exp_done = 1'b0;
  logic         hold_chk = 1'b0;
  logic [127:0] hold_key = 128'h0;
  logic [3:0]   hold_num = 4'd0;
  logic [131:0] ent;

  // Monitor: done timing, hold under backpressure, busy, and scoreboard pops.
  always @(negedge clk) begin
    check("done", {127'h0, bus.done}, {127'h0, exp_done});
    if (hold_chk) begin
      check("hold_valid", {127'h0, bus.key_valid}, 128'h1);
      check("hold_key", bus.round_key, hold_key);
      check("hold_num", {124'h0, bus.round_num}, {124'h0, hold_num});
    end
    if (bus.key_valid) check("busy", {127'h0, bus.busy}, 128'h1);
    if (bus.key_valid && bus.key_ready) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_key: got round %0d key %h expected none", bus.round_num, bus.round_key);
      end else begin
        ent = sb_q.pop_front();
        check("round_num", {124'h0, bus.round_num}, {124'h0, ent[131:128]});
        check("round_key", bus.round_key, ent[127:0]);
      end
    end
    exp_done = bus.key_valid && bus.key_ready && (bus.round_num == 4'd0) && !rst;
    hold_chk = bus.key_valid && !bus.key_ready && !rst;
    hold_key = bus.round_key;
    hold_num = bus.round_num;
  end

  int vcnt;

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.key_in = 128'h0;
    repeat (3) @(negedge clk);
    check("rst_valid", {127'h0, bus.key_valid}, 128'h0);
    check("rst_busy", {127'h0, bus.busy}, 128'h0);
    check("rst_key", bus.round_key, 128'h0);
    check("rst_num", {124'h0, bus.round_num}, 128'h0);
    #1 rst = 1'b0;
    @(negedge clk);

    // FIPS-197 A.1 with the consumer always ready.
    expand(A1_KEY0);
    check("a1_model_r9", ek[9], A1_KEY9);
    check("a1_model_r10", ek[10], A1_KEY10);
    ek[0] = A1_KEY0;
    issue_start(A1_KEY10);
    vcnt = 0;
    for (int i = 0; i < 50 && bus.key_valid; i++) begin
      vcnt++;
      @(negedge clk);
    end
    check("a1_valid_cycles", 128'(vcnt), 128'd11);
    wait_done();
    @(negedge clk);
    check("idle_after_done", {126'h0, bus.busy, bus.done}, 128'h0);

    // Same key under random backpressure.
    ready_mode = 1;
    issue_start(A1_KEY10);
    wait_done();
    ready_mode = 0;
    repeat (2) @(negedge clk);

    // Start while busy is ignored; a start right after done reloads.
    issue_start(A1_KEY10);
    wait_round(4'd5);
    bus.start = 1'b1;
    bus.key_in = 128'h0123456789abcdef0123456789abcdef;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();
    @(negedge clk);
    issue_start(A1_KEY10);
    wait_done();
    repeat (2) @(negedge clk);

    // Reset mid-sequence abandons it without a done pulse.
    issue_start(A1_KEY10);
    wait_round(4'd6);
    #1;
    sb_q.delete();
    rst = 1'b1;
    @(negedge clk);
    #1 rst = 1'b0;
    check("mid_rst_valid", {127'h0, bus.key_valid}, 128'h0);
    check("mid_rst_busy", {127'h0, bus.busy}, 128'h0);
    check("mid_rst_key", bus.round_key, 128'h0);
    @(negedge clk);
    issue_start(A1_KEY10);
    wait_done();
    repeat (2) @(negedge clk);

    // All-zero and all-ones keys: every Rcon value and many S-box bytes.
    expand(128'h0);
    issue_start(ek[10]);
    wait_done();
    repeat (2) @(negedge clk);
    expand({128{1'b1}});
    ready_mode = 1;
    issue_start(ek[10]);
    wait_done();
    ready_mode = 0;
    repeat (3) @(negedge clk);

    check("scoreboard_empty", 128'(sb_q.size()), 128'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/aes_inv_key_sched.md
Name: aes_inv_key_sched

Overview:
- Decryption-side key schedule. It is the reverse-direction counterpart of the encryption key expansion and its round-constant step.
- It is loaded with the final (round 10) AES-128 round key and steps backward through the schedule.
- It emits round keys 10, 9, …, 0 to the inverse-cipher datapath over a valid/ready handshake.
- It computes one key per accepted handshake using an internal S-box and reverse round-constant removal.

Parameters:
- NR, 10, number of AES rounds (AES-128 only; the block is not required to support other values)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous reset, active-high
- start  input  1  single-cycle request to begin a sequence; sampled only in IDLE
- key_in  input  128  round-10 key; w0 = bits [127:96], w3 = bits [31:0]; sampled on the accepted start
- key_ready  input  1  consumer accepts round_key this cycle
- round_key  output  128  current round key
- round_num  output  4  round index of round_key (10 down to 0)
- key_valid  output  1  round_key/round_num valid
- busy  output  1  sequence in progress
- done  output  1  one-cycle pulse after round 0 is accepted

Behaviour:
- Interface: one clock domain, clk. Reset rst is synchronous and active-high.
- Reset (any state, including mid-sequence): state goes to IDLE. round_key = 0, round_num = 0, key_valid = 0, busy = 0, done = 0. An in-flight sequence is abandoned with no done pulse.
- States: IDLE, EMIT, FINISH.
- IDLE:
  - done = 0.
  - On start = 1: next edge loads round_key = key_in and round_num = NR, sets key_valid = 1 and busy = 1, and goes to EMIT.
  - Latency from start to first valid key: 1 cycle.
- EMIT:
  - round_key and round_num are held stable while key_valid = 1 and key_ready = 0.
  - Handshake with round_num > 0: on that edge round_key becomes the previous key (below), round_num decrements, and key_valid stays 1. With key_ready held high, keys stream back-to-back at one per cycle: 11 keys in 11 cycles.
  - Handshake with round_num = 0: next edge clears key_valid and busy, pulses done = 1, and goes to FINISH.
- FINISH: one cycle. done returns to 0 at the next edge and the state goes to IDLE. start is ignored in this cycle.
- start while busy or in FINISH: ignored. key_in is sampled only on the accepted start.
- Previous-key computation (combinational from the current key, with r = round_num):
  - w3' = w3 ^ w2
  - w2' = w2 ^ w1
  - w1' = w1 ^ w0
  - w0' = w0 ^ SubWord(RotWord(w3')) ^ Rcon(r)
  - RotWord({a,b,c,d}) = {b,c,d,a}.
  - SubWord applies the AES forward S-box to each byte. This is the forward S-box, not the inverse.
  - Rcon(r) places the constant in the MSB byte: r = 1..10 → 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36. The other three bytes are 00.
  - For r = 0 or r > 10, Rcon = 0; this is unreachable in normal operation.
- round_num never wraps below 0. Once 0 is accepted, no further computation occurs.
- The S-box is an internal 256-entry combinational lookup with 4 instances. It is purely combinational with no registered lookup, so it adds no latency.

Test Plan:
- FIPS-197 Appendix A.1 key, start with key_in = d014f9a8c9ee2589e13f0cc8b6630ca6 and key_ready = 1:
  - Expect round_num 10 first, then 9 with round_key ac7766f319fadc2128d12941575c006e.
  - Round 0 with round_key 2b7e151628aed2a6abf7158809cf4f3c, 11 consecutive valid cycles.
  - done pulses exactly one cycle after round 0 is accepted.
- Backpressure: same key, key_ready toggled in a random pattern. round_key and round_num must hold while key_ready = 0, the same 11 keys must appear in order with no skips or repeats, and busy stays 1 throughout.
- start asserted again at round 5: ignored, and the sequence continues unchanged to round 0. A start issued the cycle after done reloads correctly and again yields first key round_num = 10.
- Reset at round 6 (rst = 1 for one cycle): next cycle key_valid = 0, busy = 0, round_key = 0, and no done pulse. A subsequent start with the A.1 round-10 key produces the full correct sequence.
- Per-round Rcon coverage: compare every emitted key against a software forward expansion of the all-zero key and of key ffff…ff. All 11 keys must match for each, exercising all 10 Rcon values and the S-box byte paths.
